// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: serial line in, byte/status out, plus FSM debug taps.
// rx_ready acts as valid for rd_data; a low rd_n for one clk is the acknowledge that clears it.
interface uart_rx_if;
  logic       iUart_rx;
  logic       rd_n;
  logic [7:0] rd_data;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;
  logic [1:0] dbg_state;
  logic [3:0] dbg_scnt;
  logic       dbg_tick;

  modport slave (
    input  iUart_rx, rd_n,
    output rd_data, rx_ready, overrun, frame_err, rx_busy,
    output dbg_state, dbg_scnt, dbg_tick
  );

  modport master (
    output iUart_rx, rd_n,
    input  rd_data, rx_ready, overrun, frame_err, rx_busy,
    input  dbg_state, dbg_scnt, dbg_tick
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling, 3-sample majority vote,
// holding register with ready/overrun/framing-error flags cleared by rd_n.
module uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] div_cnt_q;
  logic          tick;
  logic          rxs;
  logic          maj;

  state_t        state_q;
  logic [3:0]    scnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          prev_s_q;
  logic          smp7_q, smp8_q;
  logic [7:0]    rd_data_q;
  logic          rx_ready_q, overrun_q, frame_err_q, rx_busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.iUart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt_q <= '0;
    else if (tick) div_cnt_q <= '0;
    else           div_cnt_q <= div_cnt_q + 1'b1;
  end

  assign tick = (div_cnt_q == DIV_M1);

  // The third sample is the live value at scnt 9, so the vote needs no extra cycle.
  assign maj = (smp7_q & smp8_q) | (smp7_q & rxs) | (smp8_q & rxs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      prev_s_q    <= 1'b0;
      smp7_q      <= 1'b0;
      smp8_q      <= 1'b0;
      rd_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_busy_q <= (state_q != IDLE);

      // Clears come first so a byte or error finishing in the same cycle overrides them.
      if (!bus.rd_n) begin
        rx_ready_q  <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      if (tick) begin
        if (state_q == IDLE) begin
          prev_s_q <= rxs;
          if (prev_s_q && !rxs) begin
            state_q <= START;
            scnt_q  <= '0;
          end
        end else begin
          scnt_q <= scnt_q + 4'd1;
          if (scnt_q == 4'd7) smp7_q <= rxs;
          if (scnt_q == 4'd8) smp8_q <= rxs;

          case (state_q)
            START: begin
              if (scnt_q == 4'd9 && maj) begin
                state_q  <= IDLE;
                prev_s_q <= 1'b0;
              end else if (scnt_q == 4'd15) begin
                state_q   <= DATA;
                scnt_q    <= '0;
                bit_idx_q <= '0;
              end
            end
            DATA: begin
              if (scnt_q == 4'd9) shift_q <= {maj, shift_q[7:1]};
              if (scnt_q == 4'd15) begin
                scnt_q <= '0;
                if (bit_idx_q == 3'd7) state_q <= STOP;
                else                   bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
            STOP: begin
              // Leaving at mid-stop lets a following start edge be caught on short stop bits;
              // prev_s is cleared so a held-low line must go high before the next frame.
              if (scnt_q == 4'd9) begin
                if (maj) begin
                  rd_data_q  <= shift_q;
                  rx_ready_q <= 1'b1;
                  if (rx_ready_q && bus.rd_n) overrun_q <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
                state_q  <= IDLE;
                prev_s_q <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_scnt  = scnt_q;
  assign bus.dbg_tick  = tick;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud tolerance, overrun, glitch rejection, break/framing error,
// mid-frame reset and read strobe coinciding with byte completion.
module tb_uart_rx;

  localparam int CPB = 432;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_HZ     (50000000),
    .BAUD       (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Driver tasks
  task automatic drive_bit(input logic b, input int cpb);
    bus.iUart_rx = b;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int cpb, input logic stop_bit);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
    drive_bit(stop_bit, cpb);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, CPB);
  endtask

  task automatic pulse_rd;
    @(negedge clk);
    bus.rd_n = 1'b0;
    @(negedge clk);
    bus.rd_n = 1'b1;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   bauds [3];
    logic found;
    n_checks     = 0;
    n_errors     = 0;
    bauds[0]     = 432;
    bauds[1]     = 445;
    bauds[2]     = 419;
    found        = 1'b0;
    reset_n      = 1'b0;
    bus.iUart_rx = 1'b1;
    bus.rd_n     = 1'b1;

    repeat (5) @(negedge clk);
    check("reset_rd_data",   {24'd0, bus.rd_data}, 32'h00);
    check("reset_rx_ready",  {31'd0, bus.rx_ready}, 32'd0);
    check("reset_overrun",   {31'd0, bus.overrun}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_rx_busy",   {31'd0, bus.rx_busy}, 32'd0);
    reset_n = 1'b1;
    idle_bits(2);

    // 1: 0x55 at nominal and +-3% bit periods
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h55, bauds[k], 1'b1);
      idle_bits(2);
      check($sformatf("t1_ready_%0d", bauds[k]), {31'd0, bus.rx_ready}, 32'd1);
      check($sformatf("t1_data_%0d", bauds[k]), {24'd0, bus.rd_data}, 32'h55);
      check($sformatf("t1_ferr_%0d", bauds[k]), {31'd0, bus.frame_err}, 32'd0);
      pulse_rd();
    end
    check("t1_ready_cleared", {31'd0, bus.rx_ready}, 32'd0);
    check("t1_overrun_clear", {31'd0, bus.overrun}, 32'd0);

    // 2: back-to-back bytes without a read
    send_byte(8'hA5, CPB, 1'b1);
    send_byte(8'h3C, CPB, 1'b1);
    idle_bits(2);
    check("t2_data",    {24'd0, bus.rd_data}, 32'h3C);
    check("t2_ready",   {31'd0, bus.rx_ready}, 32'd1);
    check("t2_overrun", {31'd0, bus.overrun}, 32'd1);
    pulse_rd();
    check("t2_ready_clr",   {31'd0, bus.rx_ready}, 32'd0);
    check("t2_overrun_clr", {31'd0, bus.overrun}, 32'd0);
    check("t2_data_kept",   {24'd0, bus.rd_data}, 32'h3C);

    // 3: 100-clk glitch is a false start
    bus.iUart_rx = 1'b0;
    repeat (100) @(negedge clk);
    bus.iUart_rx = 1'b1;
    repeat (50) @(negedge clk);
    check("t3_busy_high", {31'd0, bus.rx_busy}, 32'd1);
    repeat (250) @(negedge clk);
    check("t3_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    check("t3_ready",    {31'd0, bus.rx_ready}, 32'd0);
    check("t3_data",     {24'd0, bus.rd_data}, 32'h3C);
    idle_bits(1);

    // 4: framing error followed by a 20-bit break, then a good byte
    send_byte(8'hFF, CPB, 1'b0);
    for (int i = 0; i < 10; i++) drive_bit(1'b0, CPB);
    check("t4_ferr_break",  {31'd0, bus.frame_err}, 32'd1);
    check("t4_ready_break", {31'd0, bus.rx_ready}, 32'd0);
    check("t4_busy_break",  {31'd0, bus.rx_busy}, 32'd0);
    check("t4_data_break",  {24'd0, bus.rd_data}, 32'h3C);
    for (int i = 0; i < 10; i++) drive_bit(1'b0, CPB);
    check("t4_busy_end_break", {31'd0, bus.rx_busy}, 32'd0);
    idle_bits(2);
    send_byte(8'h81, CPB, 1'b1);
    idle_bits(2);
    check("t4_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("t4_data",  {24'd0, bus.rd_data}, 32'h81);
    check("t4_ferr",  {31'd0, bus.frame_err}, 32'd1);
    pulse_rd();
    check("t4_ferr_clr", {31'd0, bus.frame_err}, 32'd0);

    // 5: reset in the middle of data bit 4 of 0xF0
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, CPB);
    bus.iUart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("t5_busy_before", {31'd0, bus.rx_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_data",  {24'd0, bus.rd_data}, 32'h00);
    check("t5_rst_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t5_rst_ovr",   {31'd0, bus.overrun}, 32'd0);
    check("t5_rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
    check("t5_rst_busy",  {31'd0, bus.rx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    send_byte(8'h12, CPB, 1'b1);
    idle_bits(2);
    check("t5_data",    {24'd0, bus.rd_data}, 32'h12);
    check("t5_ready",   {31'd0, bus.rx_ready}, 32'd1);
    check("t5_overrun", {31'd0, bus.overrun}, 32'd0);

    // 6: read strobe on the same edge that completes 0x7E while rx_ready is still set
    fork
      send_byte(8'h7E, CPB, 1'b1);
      begin
        for (int k = 0; k < 6000 && !found; k++) begin
          @(negedge clk);
          if (bus.dbg_state == 2'd3 && bus.dbg_scnt == 4'd9 && bus.dbg_tick) begin
            found    = 1'b1;
            bus.rd_n = 1'b0;
            @(negedge clk);
            bus.rd_n = 1'b1;
          end
        end
      end
    join
    check("t6_stop_seen", {31'd0, found}, 32'd1);
    idle_bits(1);
    check("t6_ready",   {31'd0, bus.rx_ready}, 32'd1);
    check("t6_data",    {24'd0, bus.rd_data}, 32'h7E);
    check("t6_overrun", {31'd0, bus.overrun}, 32'd0);
    check("t6_ferr",    {31'd0, bus.frame_err}, 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
